// File: rtl/axi_addr_rr_arbiter_if.sv
// Bundle of the master-side, downstream and decode-error signals of the address arbiter.
// The arbiter is the slave of this bundle. The driver of the bundle (masters, interconnect, map) uses the master modport.
interface axi_addr_rr_arbiter_if #(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic [NB_MASTER-1:0]            m_valid_i;
  logic [NB_MASTER-1:0]            m_ready_o;
  logic [NB_MASTER*ADDR_WIDTH-1:0] m_addr_i;
  logic [NB_MASTER*ID_WIDTH-1:0]   m_id_i;
  logic [NB_SLAVE*ADDR_WIDTH-1:0]  start_addr_i;
  logic [NB_SLAVE*ADDR_WIDTH-1:0]  end_addr_i;
  logic                            s_valid_o;
  logic                            s_ready_i;
  logic [ADDR_WIDTH-1:0]           s_addr_o;
  logic [ID_WIDTH+1:0]             s_id_o;
  logic [NB_SLAVE-1:0]             s_sel_o;
  logic                            done_i;
  logic                            err_valid_o;
  logic                            err_ready_i;
  logic [ID_WIDTH+1:0]             err_id_o;
  logic [3:0]                      outstanding_o;

  modport slave (
    input  m_valid_i, m_addr_i, m_id_i, start_addr_i, end_addr_i,
           s_ready_i, done_i, err_ready_i,
    output m_ready_o, s_valid_o, s_addr_o, s_id_o, s_sel_o,
           err_valid_o, err_id_o, outstanding_o
  );

  modport master (
    output m_valid_i, m_addr_i, m_id_i, start_addr_i, end_addr_i,
           s_ready_i, done_i, err_ready_i,
    input  m_ready_o, s_valid_o, s_addr_o, s_id_o, s_sel_o,
           err_valid_o, err_id_o, outstanding_o
  );
endinterface

// File: rtl/axi_addr_rr_arbiter.sv
// Round-robin address-channel arbiter with region decode, ID extension, outstanding throttle
// and a local decode-error responder for unmapped addresses.
module axi_addr_rr_arbiter #(
  parameter int NB_MASTER       = 3,
  parameter int NB_SLAVE        = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_addr_rr_arbiter_if.slave  bus
);
  localparam int          IDW  = ID_WIDTH + 2;
  localparam logic [2:0]  NBM  = 3'(NB_MASTER);
  localparam logic [1:0]  LAST = 2'(NB_MASTER - 1);
  localparam logic [3:0]  MAX4 = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, FWD, ERR} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rr_q, rr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [NB_SLAVE-1:0]   sel_q, sel_d;

  logic [3:0]            valid_pad;
  logic [2:0]            cand;
  logic                  found;
  logic [1:0]            win;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  hit;
  logic [NB_SLAVE-1:0]   hit_sel;
  logic                  grant;
  logic                  fwd_hs;

  assign valid_pad = 4'(bus.m_valid_i);

  // First valid master at or after the RR pointer, wrapping modulo NB_MASTER
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NB_MASTER; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= NBM) cand = cand - NBM;
      if (!found && valid_pad[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_id   = '0;
    for (int m = 0; m < NB_MASTER; m++) begin
      if (win == 2'(m)) begin
        win_addr = bus.m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        win_id   = bus.m_id_i[m*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  // Lowest-index region wins on overlap, keeping the select one-hot
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = 0; i < NB_SLAVE; i++) begin
      if (!hit && win_addr >= bus.start_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]
               && win_addr <= bus.end_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit        = 1'b1;
        hit_sel[i] = 1'b1;
      end
    end
  end

  assign grant  = !rst && (state_q == IDLE) && found && (cnt_q < MAX4);
  assign fwd_hs = (state_q == FWD) && bus.s_ready_i;

  always_comb begin
    bus.m_ready_o = '0;
    for (int m = 0; m < NB_MASTER; m++) begin
      if (grant && win == 2'(m)) bus.m_ready_o[m] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    id_d    = id_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          addr_d  = win_addr;
          id_d    = {win, win_id};
          sel_d   = hit_sel;
          rr_d    = (win == LAST) ? 2'd0 : win + 2'd1;
          state_d = hit ? FWD : ERR;
        end
      end
      FWD:     if (bus.s_ready_i) state_d = IDLE;
      ERR:     if (bus.err_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Completion and new forward in the same cycle cancel out
    if (fwd_hs && !bus.done_i)                      cnt_d = cnt_q + 4'd1;
    else if (!fwd_hs && bus.done_i && cnt_q != '0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.s_valid_o     = (state_q == FWD);
  assign bus.err_valid_o   = (state_q == ERR);
  assign bus.s_addr_o      = addr_q;
  assign bus.s_id_o        = id_q;
  assign bus.s_sel_o       = sel_q;
  assign bus.err_id_o      = id_q;
  assign bus.outstanding_o = cnt_q;
endmodule

// File: tb/tb_axi_addr_rr_arbiter.sv
// Self-checking bench for axi_addr_rr_arbiter: decode table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_axi_addr_rr_arbiter;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_addr_rr_arbiter_if #(.NB_MASTER(3), .NB_SLAVE(3), .ADDR_WIDTH(32), .ID_WIDTH(2)) bus ();

  axi_addr_rr_arbiter #(
    .NB_MASTER(3), .NB_SLAVE(3), .ADDR_WIDTH(32), .ID_WIDTH(2), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 idle, 1 forwarding, 2 error response
  int          md_state, md_rr, md_cnt;
  logic [31:0] md_addr;
  logic [3:0]  md_id;
  logic [2:0]  md_sel;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  sel;
    logic        err;
  } dec_vec_t;
  dec_vec_t tbl[10];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int md_pick();
    if (md_state != 0 || md_cnt >= MAXO) return -1;
    for (int k = 0; k < 3; k++) begin
      int j = (md_rr + k) % 3;
      if (bus.m_valid_i[j]) return j;
    end
    return -1;
  endfunction

  function automatic int md_region(logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if (a >= bus.start_addr_i[i*32 +: 32] && a <= bus.end_addr_i[i*32 +: 32]) return i;
    return -1;
  endfunction

  task automatic md_reset();
    md_state = 0; md_rr = 0; md_cnt = 0;
    md_addr = '0; md_id = '0; md_sel = '0;
  endtask

  task automatic check_outputs();
    int w;
    logic [2:0] er;
    w  = md_pick();
    er = (w >= 0) ? 3'(1 << w) : 3'b000;
    chk("m_ready", 64'(bus.m_ready_o), 64'(er));
    chk("s_valid", 64'(bus.s_valid_o), 64'(md_state == 1));
    chk("err_valid", 64'(bus.err_valid_o), 64'(md_state == 2));
    chk("outstanding", 64'(bus.outstanding_o), 64'(md_cnt));
    if (md_state == 1) begin
      chk("s_addr", 64'(bus.s_addr_o), 64'(md_addr));
      chk("s_id", 64'(bus.s_id_o), 64'(md_id));
      chk("s_sel", 64'(bus.s_sel_o), 64'(md_sel));
    end
    if (md_state == 2) chk("err_id", 64'(bus.err_id_o), 64'(md_id));
  endtask

  task automatic md_update();
    int w, r;
    bit hs;
    w  = md_pick();
    hs = (md_state == 1) && bus.s_ready_i;
    if (hs && !bus.done_i) md_cnt++;
    else if (!hs && bus.done_i && md_cnt > 0) md_cnt--;
    case (md_state)
      0: if (w >= 0) begin
        md_addr  = bus.m_addr_i[w*32 +: 32];
        r        = md_region(md_addr);
        md_id    = {2'(w), bus.m_id_i[w*2 +: 2]};
        md_sel   = (r >= 0) ? 3'(1 << r) : 3'b000;
        md_state = (r >= 0) ? 1 : 2;
        md_rr    = (w + 1) % 3;
      end
      1: if (bus.s_ready_i) md_state = 0;
      2: if (bus.err_ready_i) md_state = 0;
      default: md_state = 0;
    endcase
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    md_update();
    @(negedge clk);
  endtask

  task automatic set_map(logic [31:0] r1_start);
    bus.start_addr_i = {32'h1A10_0000, r1_start, 32'h0000_0000};
    bus.end_addr_i   = {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF};
  endtask

  task automatic idle_inputs();
    bus.m_valid_i = '0; bus.m_addr_i = '0; bus.m_id_i = '0;
    bus.s_ready_i = 1'b0; bus.done_i = 1'b0; bus.err_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", 64'(bus.m_ready_o), 64'd0);
    chk("rst_s_valid", 64'(bus.s_valid_o), 64'd0);
    chk("rst_err_valid", 64'(bus.err_valid_o), 64'd0);
    chk("rst_s_addr", 64'(bus.s_addr_o), 64'd0);
    chk("rst_s_id", 64'(bus.s_id_o), 64'd0);
    chk("rst_s_sel", 64'(bus.s_sel_o), 64'd0);
    chk("rst_err_id", 64'(bus.err_id_o), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    rst = 1'b0;
    md_reset();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h000F_FFFF;
      2: return 32'h0008_0000 + $urandom_range(0, 255);
      3: return 32'h0FFF_FFFF;
      4: return 32'h1A10_0000 + $urandom_range(0, 32'h1_FFFF);
      5: return 32'h1A12_0000;
      6: return 32'h2000_0000;
      default: return 32'h0010_0000 + $urandom_range(0, 32'hFFFF);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int order[6];
    int n;
    tbl[0] = '{32'h0000_0000, 3'b001, 1'b0};
    tbl[1] = '{32'h000F_FFFF, 3'b001, 1'b0};
    tbl[2] = '{32'h0010_0000, 3'b010, 1'b0};
    tbl[3] = '{32'h0FFF_FFFF, 3'b010, 1'b0};
    tbl[4] = '{32'h1000_0000, 3'b000, 1'b1};
    tbl[5] = '{32'h1A0F_FFFF, 3'b000, 1'b1};
    tbl[6] = '{32'h1A10_0000, 3'b100, 1'b0};
    tbl[7] = '{32'h1A11_FFFF, 3'b100, 1'b0};
    tbl[8] = '{32'h1A12_0000, 3'b000, 1'b1};
    tbl[9] = '{32'hFFFF_FFFF, 3'b000, 1'b1};

    set_map(32'h0010_0000);
    md_reset();
    @(negedge clk);
    do_reset();

    // Basic forward from master1
    bus.m_valid_i = 3'b010;
    bus.m_addr_i  = {32'h0, 32'h0010_0040, 32'h0};
    bus.m_id_i    = 6'b00_01_00;
    bus.s_ready_i = 1'b1;
    #1 chk("tp1_m_ready", 64'(bus.m_ready_o), 64'b010);
    cycle();
    bus.m_valid_i = '0;
    #1;
    chk("tp1_s_valid", 64'(bus.s_valid_o), 64'd1);
    chk("tp1_s_sel", 64'(bus.s_sel_o), 64'b010);
    chk("tp1_s_id", 64'(bus.s_id_o), 64'b0101);
    chk("tp1_s_addr", 64'(bus.s_addr_o), 64'h0010_0040);
    cycle();
    #1 chk("tp1_outstanding", 64'(bus.outstanding_o), 64'd1);
    bus.done_i = 1'b1;
    cycle();
    bus.done_i = 1'b0;
    cycle();

    // Decode table; done held high so count never moves (and never underflows)
    bus.s_ready_i = 1'b1; bus.err_ready_i = 1'b1; bus.done_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.m_valid_i = 3'(1 << (i % 3));
      bus.m_addr_i  = {3{tbl[i].addr}};
      bus.m_id_i    = {3{2'(i)}};
      cycle();
      bus.m_valid_i = '0;
      #1;
      chk("dec_sel", 64'(bus.s_sel_o & {3{bus.s_valid_o}}), 64'(tbl[i].sel));
      chk("dec_err", 64'(bus.err_valid_o), 64'(tbl[i].err));
      cycle();
    end
    bus.done_i = 1'b0;
    #1 chk("dec_count", 64'(bus.outstanding_o), 64'd0);

    // Round-robin fairness with all masters valid
    do_reset();
    set_map(32'h0010_0000);
    bus.m_valid_i = 3'b111;
    bus.m_addr_i  = {32'h100, 32'h200, 32'h300};
    bus.s_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      bus.done_i = (md_state == 1);
      #1;
      for (int j = 0; j < 3; j++) if (bus.m_ready_o[j] && n < 6) order[n++] = j;
      cycle();
    end
    chk("rr_grants", 64'(n), 64'd6);
    for (int k = 0; k < n; k++) chk("rr_order", 64'(order[k]), 64'(k % 3));
    bus.m_valid_i = '0;
    bus.done_i = (md_state == 1);
    cycle();
    bus.done_i = 1'b0;
    cycle();

    // Decode error held until accepted
    bus.m_valid_i = 3'b001;
    bus.m_addr_i  = {64'h0, 32'h2000_0000};
    bus.m_id_i    = 6'b00_00_11;
    bus.err_ready_i = 1'b0;
    cycle();
    bus.m_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("err_hold_valid", 64'(bus.err_valid_o), 64'd1);
      chk("err_hold_id", 64'(bus.err_id_o), 64'b0011);
      chk("err_no_fwd", 64'(bus.s_valid_o), 64'd0);
      cycle();
    end
    bus.err_ready_i = 1'b1;
    cycle();
    bus.err_ready_i = 1'b0;
    #1;
    chk("err_done_valid", 64'(bus.err_valid_o), 64'd0);
    chk("err_count", 64'(bus.outstanding_o), 64'd0);

    // Outstanding limit
    bus.m_valid_i = 3'b001;
    bus.m_addr_i  = {64'h0, 32'h0000_1000};
    bus.s_ready_i = 1'b1;
    for (int c = 0; c < 20 && md_cnt < MAXO; c++) cycle();
    for (int c = 0; c < 3; c++) begin
      #1 chk("limit_no_grant", 64'(bus.m_ready_o), 64'd0);
      chk("limit_count", 64'(bus.outstanding_o), 64'(MAXO));
      cycle();
    end
    bus.done_i = 1'b1;
    cycle();
    bus.done_i = 1'b0;
    #1 chk("limit_regrant", 64'(bus.m_ready_o), 64'b001);
    cycle();
    bus.m_valid_i = '0;
    cycle();
    #1 chk("limit_refill", 64'(bus.outstanding_o), 64'(MAXO));
    for (int c = 0; c < MAXO; c++) begin
      bus.done_i = 1'b1;
      cycle();
    end
    bus.done_i = 1'b0;
    #1 chk("limit_drain", 64'(bus.outstanding_o), 64'd0);

    // Downstream stall with other masters toggling
    bus.m_valid_i = 3'b010;
    bus.m_addr_i  = {32'h0, 32'h1A10_0010, 32'h0};
    bus.m_id_i    = 6'b00_10_00;
    bus.s_ready_i = 1'b0;
    cycle();
    for (int c = 0; c < 5; c++) begin
      bus.m_valid_i = 3'($urandom_range(0, 7));
      bus.m_addr_i  = {32'h0000_0040, 32'h0000_0080, 32'h0FFF_0000};
      #1;
      chk("stall_m_ready", 64'(bus.m_ready_o), 64'd0);
      chk("stall_s_addr", 64'(bus.s_addr_o), 64'h1A10_0010);
      chk("stall_s_id", 64'(bus.s_id_o), 64'b0110);
      chk("stall_s_sel", 64'(bus.s_sel_o), 64'b100);
      cycle();
    end
    bus.m_valid_i = '0;
    bus.s_ready_i = 1'b1;
    bus.done_i    = 1'b1;
    cycle();
    bus.done_i = 1'b0;
    #1 chk("stall_hs_done_count", 64'(bus.outstanding_o), 64'd0);

    // Asynchronous reset while forwarding
    bus.m_valid_i = 3'b001;
    bus.m_addr_i  = {64'h0, 32'h0000_2000};
    bus.s_ready_i = 1'b0;
    cycle();
    cycle();
    bus.m_valid_i = 3'b101;
    #3 rst = 1'b1;
    #1;
    chk("arst_s_valid", 64'(bus.s_valid_o), 64'd0);
    chk("arst_m_ready", 64'(bus.m_ready_o), 64'd0);
    chk("arst_s_addr", 64'(bus.s_addr_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    md_reset();
    bus.m_valid_i = 3'b100;
    bus.m_addr_i  = {32'h0010_0800, 64'h0};
    bus.m_id_i    = 6'b10_00_00;
    bus.s_ready_i = 1'b1;
    #1 chk("arst_m2_grant", 64'(bus.m_ready_o), 64'b100);
    cycle();
    bus.m_valid_i = '0;
    #1 chk("arst_m2_id", 64'(bus.s_id_o), 64'b1010);
    cycle();
    cycle();

    // Randomized traffic on an overlapping map
    do_reset();
    set_map(32'h0008_0000);
    for (int c = 0; c < 800; c++) begin
      bus.m_valid_i   = 3'($urandom_range(0, 7));
      bus.m_addr_i    = {rand_addr(), rand_addr(), rand_addr()};
      bus.m_id_i      = 6'($urandom_range(0, 63));
      bus.s_ready_i   = ($urandom_range(0, 9) < 7);
      bus.err_ready_i = ($urandom_range(0, 9) < 5);
      bus.done_i      = ($urandom_range(0, 9) < 3);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
